cipher_feeder: RTL and testbench

Upstream feeder for the chained-XOR stream-cipher stage. It accepts plaintext bytes over a valid/ready handshake and buffers them in a small FIFO. For each byte it drives the cipher's data byte, `encrypt` and `inc` strobe with guaranteed setup/hold, and tracks how many bytes the cipher currently holds. Its outputs connect directly to the cipher's `ui_in`, `uio_in[1]` (encrypt) and `uio_in[0]` (inc).

---
 rtl/cipher_pkg.sv | 27 ++
 rtl/cipher_feeder_if.sv | 44 ++++
 rtl/cipher_feeder_fifo.sv | 84 ++++++++
 rtl/cipher_feeder.sv | 181 ++++++++++++++++++
 tb/tb_cipher_feeder.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cipher_pkg.sv
// ---------------------------------------------------------------------------
// cipher_pkg
// Shared types and constants for the stream-cipher feeder slice.
//   feeder_state_t : feeder FSM states (IDLE, SETUP, STROBE, HOLD)
//   BYTE_W         : width of one plaintext byte
//   ASCII_MIN/MAX  : printable-ASCII window used by the optional byte filter
//   isPrintable()  : true when a byte lies inside that window
// ---------------------------------------------------------------------------
package cipher_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] ASCII_MIN = 8'h20;
    localparam logic [BYTE_W-1:0] ASCII_MAX = 8'h7E;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } feeder_state_t;

    function automatic logic isPrintable(input logic [BYTE_W-1:0] b);
        return (b >= ASCII_MIN) && (b <= ASCII_MAX);
    endfunction

endpackage

// File: rtl/cipher_feeder_if.sv
// ---------------------------------------------------------------------------
// cipher_feeder_if
// Bundles the feeder's byte handshake and its cipher-facing outputs.
//   in_data/in_valid/in_ready : plaintext byte handshake (producer -> feeder)
//   clear                     : synchronous flush request
//   enc_data/enc_encrypt/enc_inc : drive the cipher's ui_in, uio_in[1], uio_in[0]
//   msg_count/msg_full        : bytes strobed since reset/clear, and saturation flag
//   busy                      : feeder FSM not idle
//   drop_err                  : pulse when a byte is filtered out
// Modports: master = producer/observer side, slave = the feeder itself.
// ---------------------------------------------------------------------------
interface cipher_feeder_if
    import cipher_pkg::*;
#(
    parameter int MSG_MAX = 4
) ();

    localparam int CNT_W = $clog2(MSG_MAX + 1);

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              clear;
    logic [BYTE_W-1:0] enc_data;
    logic              enc_encrypt;
    logic              enc_inc;
    logic [CNT_W-1:0]  msg_count;
    logic              msg_full;
    logic              busy;
    logic              drop_err;

    modport master (
        output in_data, in_valid, clear,
        input  in_ready, enc_data, enc_encrypt, enc_inc,
               msg_count, msg_full, busy, drop_err
    );

    modport slave (
        input  in_data, in_valid, clear,
        output in_ready, enc_data, enc_encrypt, enc_inc,
               msg_count, msg_full, busy, drop_err
    );

endinterface

// File: rtl/cipher_feeder_fifo.sv
// ---------------------------------------------------------------------------
// feeder_fifo
// DEPTH x BYTE_W register FIFO buffering plaintext bytes for the feeder.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (ignored when full)
//   i_pop      : drop the head entry (ignored when empty)
//   i_flush    : synchronous empty, wins over push and pop
//   i_data     : byte to write
//   o_head     : current head entry
//   o_count    : number of stored entries (0..DEPTH)
//   o_full     : o_count == DEPTH
//   o_empty    : o_count == 0
// ---------------------------------------------------------------------------
module feeder_fifo
    import cipher_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [BYTE_W-1:0]          i_data,
    output logic [BYTE_W-1:0]          o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rdPtr];

    // A full FIFO refuses a write even when a pop happens the same cycle.
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;

    // Pointer and occupancy bookkeeping; flush simply rewinds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_flush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

endmodule

// File: rtl/cipher_feeder.sv
// ---------------------------------------------------------------------------
// cipher_feeder
// Upstream feeder for the chained-XOR stream-cipher stage. Plaintext bytes
// arrive over a valid/ready handshake, are buffered in feeder_fifo, and are
// then presented to the cipher one at a time: data and encrypt are set up one
// cycle before the one-cycle inc strobe and held GAP cycles after it.
//
// Parameters:
//   DEPTH   : FIFO entries (power of two, >= 2)
//   MSG_MAX : bytes the cipher register holds; feeding stops at this count
//   GAP     : HOLD cycles after each strobe (1..15)
// Ports:
//   clk, rst_n : sole clock, asynchronous active-low reset
//   bus        : cipher_feeder_if.slave (handshake, clear, cipher drive,
//                msg_count/msg_full, busy, drop_err)
//
// Build option: FEEDER_ASCII_FILTER_EN -- when defined, bytes outside
// 0x20..0x7E complete the handshake but are discarded and drop_err pulses;
// when undefined every accepted byte is queued and drop_err is tied 0.
// ---------------------------------------------------------------------------
module cipher_feeder
    import cipher_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MSG_MAX = 4,
    parameter int GAP     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    cipher_feeder_if.slave  bus
);

    localparam int                 CNT_W    = $clog2(MSG_MAX + 1);
    localparam int                 FIFO_CW  = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]   MSG_LAST = CNT_W'(MSG_MAX);
    localparam logic [3:0]         GAP_LAST = 4'(GAP - 1);

    logic [BYTE_W-1:0]  w_fifoHead;
    logic [FIFO_CW-1:0] w_fifoCount;
    logic               w_fifoFull;
    logic               w_fifoEmpty;

    logic               w_inReady;
    logic               w_accept;
    logic               w_keep;
    logic               w_push;
    logic               w_pop;
    logic               w_canStart;

    feeder_state_t      r_state;
    logic [BYTE_W-1:0]  r_encData;
    logic               r_encEncrypt;
    logic               r_encInc;
    logic               r_busy;
    logic               r_msgFull;
    logic [CNT_W-1:0]   r_msgCount;
    logic [3:0]         r_gapCnt;

    // Ready follows the registered occupancy; clear and reset both refuse bytes.
    assign w_inReady = rst_n & ~bus.clear & (w_fifoCount < FIFO_CW'(DEPTH));
    assign w_accept  = bus.in_valid & w_inReady;

`ifdef FEEDER_ASCII_FILTER_EN
    assign w_keep = isPrintable(bus.in_data);
`else
    assign w_keep = 1'b1;
`endif

    assign w_push = w_accept & w_keep & ~w_fifoFull;

    // A new byte may start from IDLE, or directly from the last HOLD cycle so
    // back-to-back bytes stream at one per 2+GAP cycles.
    assign w_canStart = ~w_fifoEmpty & ~r_msgFull;
    assign w_pop      = ~bus.clear & w_canStart &
                        ((r_state == IDLE) ||
                         ((r_state == HOLD) && (r_gapCnt == '0)));

    feeder_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.clear),
        .i_data  (bus.in_data),
        .o_head  (w_fifoHead),
        .o_count (w_fifoCount),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    // Feeder FSM with registered cipher drive, GAP countdown and message
    // count. Clear overrides every state but leaves enc_data untouched,
    // since the cipher register itself is not cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_encData    <= '0;
            r_encEncrypt <= 1'b0;
            r_encInc     <= 1'b0;
            r_busy       <= 1'b0;
            r_msgFull    <= 1'b0;
            r_msgCount   <= '0;
            r_gapCnt     <= '0;
        end else if (bus.clear) begin
            r_state      <= IDLE;
            r_encEncrypt <= 1'b0;
            r_encInc     <= 1'b0;
            r_busy       <= 1'b0;
            r_msgFull    <= 1'b0;
            r_msgCount   <= '0;
            r_gapCnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_encData    <= w_fifoHead;
                        r_encEncrypt <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= SETUP;
                    end
                end
                SETUP: begin
                    r_encInc <= 1'b1;
                    r_state  <= STROBE;
                end
                STROBE: begin
                    r_encInc <= 1'b0;
                    r_gapCnt <= GAP_LAST;
                    r_state  <= HOLD;
                    if (r_msgCount != MSG_LAST) begin
                        r_msgCount <= r_msgCount + 1'b1;
                        r_msgFull  <= (r_msgCount == (MSG_LAST - 1'b1));
                    end
                end
                HOLD: begin
                    if (r_gapCnt != '0) begin
                        r_gapCnt <= r_gapCnt - 1'b1;
                    end else if (w_pop) begin
                        r_encData <= w_fifoHead;
                        r_state   <= SETUP;
                    end else begin
                        r_encEncrypt <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef FEEDER_ASCII_FILTER_EN
    logic r_dropErr;

    // One-cycle pulse after an edge that handshook a non-printable byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dropErr <= 1'b0;
        end else begin
            r_dropErr <= w_accept & ~w_keep;
        end
    end

    assign bus.drop_err = r_dropErr;
`else
    assign bus.drop_err = 1'b0;
`endif

    assign bus.in_ready    = w_inReady;
    assign bus.enc_data    = r_encData;
    assign bus.enc_encrypt = r_encEncrypt;
    assign bus.enc_inc     = r_encInc;
    assign bus.busy        = r_busy;
    assign bus.msg_full    = r_msgFull;
    assign bus.msg_count   = r_msgCount;

endmodule

// File: tb/tb_cipher_feeder.sv
// ---------------------------------------------------------------------------
// tb_cipher_feeder
// Self-checking bench for cipher_feeder (DEPTH=4, MSG_MAX=4, GAP=1).
// Accepted bytes are pushed to a scoreboard queue; a monitor pops and compares
// on every enc_inc strobe and records the strobe cycle for timing checks.
// Expectations for the filtered build follow FEEDER_ASCII_FILTER_EN.
// ---------------------------------------------------------------------------
module tb_cipher_feeder;

    localparam int DEPTH   = 4;
    localparam int MSG_MAX = 4;
    localparam int GAP     = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cipher_feeder_if #(.MSG_MAX(MSG_MAX)) bus ();

    cipher_feeder #(
        .DEPTH   (DEPTH),
        .MSG_MAX (MSG_MAX),
        .GAP     (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] sb[$];
    int         strobeCycles[$];
    logic       prevInc = 1'b0;
    logic [7:0] monExp;
    int         lastAccept;
    logic       lastDrop;

    always @(posedge clk) cyc <= cyc + 1;

    // Single point of comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
        end
    endtask

    // Strobe monitor: every enc_inc cycle must carry the next expected byte.
    always @(negedge clk) begin
        if (rst_n && bus.enc_inc) begin
            if (sb.size() == 0) begin
                checkOutput("unexpectedStrobe", {24'h0, bus.enc_data}, 32'h100);
            end else begin
                monExp = sb.pop_front();
                checkOutput("strobeData", {24'h0, bus.enc_data}, {24'h0, monExp});
            end
            checkOutput("strobeEncrypt", {31'h0, bus.enc_encrypt}, 32'h1);
            checkOutput("incWidth", {31'h0, prevInc}, 32'h0);
            strobeCycles.push_back(cyc);
        end
        prevInc = bus.enc_inc;
    end

    // Offer one byte, wait (bounded) for ready, return just after the accept edge.
    task automatic applyStimulus(input logic [7:0] b);
        logic keep;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        #1;
        for (int i = 0; i < 50 && !bus.in_ready; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("acceptReady", {31'h0, bus.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        lastAccept = cyc;
        lastDrop   = bus.drop_err;
`ifdef FEEDER_ASCII_FILTER_EN
        keep = (b >= 8'h20) && (b <= 8'h7E);
`else
        keep = 1'b1;
`endif
        if (keep) sb.push_back(b);
    endtask

    task automatic idleInputs();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitStrobes(input int target, input string tag);
        for (int i = 0; i < 60 && strobeCycles.size() < target; i++) @(posedge clk);
        #1;
        checkOutput(tag, strobeCycles.size(), target);
    endtask

    // One-cycle clear with a byte offered alongside it; the byte must be refused.
    task automatic pulseClear();
        @(negedge clk);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        #1;
        checkOutput("clearBlocksReady", {31'h0, bus.in_ready}, 32'h0);
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        sb.delete();
        #1;
        checkOutput("clearMsgCount", 32'(bus.msg_count), 32'h0);
        checkOutput("clearMsgFull", {31'h0, bus.msg_full}, 32'h0);
        checkOutput("clearReady", {31'h0, bus.in_ready}, 32'h1);
        checkOutput("clearBusy", {31'h0, bus.busy}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int base;
        int first;
        int expStrobes;
        logic d0;
        logic d1;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.clear    = 1'b0;

        // Reset state
        #12;
        checkOutput("rstReady", {31'h0, bus.in_ready}, 32'h0);
        checkOutput("rstEncData", {24'h0, bus.enc_data}, 32'h0);
        checkOutput("rstEncrypt", {31'h0, bus.enc_encrypt}, 32'h0);
        checkOutput("rstInc", {31'h0, bus.enc_inc}, 32'h0);
        checkOutput("rstBusy", {31'h0, bus.busy}, 32'h0);
        checkOutput("rstMsgCount", 32'(bus.msg_count), 32'h0);
        checkOutput("rstMsgFull", {31'h0, bus.msg_full}, 32'h0);
        checkOutput("rstDrop", {31'h0, bus.drop_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("relReady", {31'h0, bus.in_ready}, 32'h1);
        checkOutput("relBusy", {31'h0, bus.busy}, 32'h0);

        // Single byte with exact latency
        $display("[TB] single byte 0x41");
        base = strobeCycles.size();
        applyStimulus(8'h41);
        t = lastAccept;
        idleInputs();
        checkOutput("t0Busy", {31'h0, bus.busy}, 32'h0);
        @(negedge clk);
        checkOutput("t1EncData", {24'h0, bus.enc_data}, 32'h41);
        checkOutput("t1Encrypt", {31'h0, bus.enc_encrypt}, 32'h1);
        checkOutput("t1Inc", {31'h0, bus.enc_inc}, 32'h0);
        @(negedge clk);
        checkOutput("t2Inc", {31'h0, bus.enc_inc}, 32'h1);
        @(negedge clk);
        checkOutput("t3Inc", {31'h0, bus.enc_inc}, 32'h0);
        checkOutput("t3MsgCount", 32'(bus.msg_count), 32'h1);
        checkOutput("t3Encrypt", {31'h0, bus.enc_encrypt}, 32'h1);
        @(negedge clk);
        checkOutput("t4Encrypt", {31'h0, bus.enc_encrypt}, 32'h0);
        checkOutput("t4Busy", {31'h0, bus.busy}, 32'h0);
        checkOutput("singleStrobes", strobeCycles.size(), base + 1);
        if (strobeCycles.size() > base)
            checkOutput("singleLatency", strobeCycles[base] - t, 32'd2);

        // Burst of six bytes into a 4-deep FIFO with a 4-byte cipher register
        $display("[TB] burst 0x61..0x66");
        pulseClear();
        base = strobeCycles.size();
        applyStimulus(8'h61);
        first = lastAccept;
        for (int i = 1; i < 6; i++) applyStimulus(8'h61 + 8'(i));
        checkOutput("burstBackToBack", lastAccept - first, 32'd5);
        checkOutput("burstFullReady", {31'h0, bus.in_ready}, 32'h0);
        idleInputs();
        waitStrobes(base + 4, "burstStrobes");
        waitCycles(8);
        checkOutput("burstNoExtra", strobeCycles.size(), base + 4);
        for (int i = 1; i < 4; i++) begin
            if (strobeCycles.size() > base + i)
                checkOutput("burstSpacing", strobeCycles[base+i] - strobeCycles[base+i-1], 32'd3);
        end
        checkOutput("burstMsgCount", 32'(bus.msg_count), 32'd4);
        checkOutput("burstMsgFull", {31'h0, bus.msg_full}, 32'h1);
        checkOutput("burstBusy", {31'h0, bus.busy}, 32'h0);
        checkOutput("burstEncrypt", {31'h0, bus.enc_encrypt}, 32'h0);
        checkOutput("burstReadyAgain", {31'h0, bus.in_ready}, 32'h1);
        checkOutput("burstLeftover", sb.size(), 32'd2);
        applyStimulus(8'h67);
        applyStimulus(8'h68);
        checkOutput("fifoHeldFull", {31'h0, bus.in_ready}, 32'h0);
        idleInputs();

        // Clear recovery from msg_full with a non-empty FIFO
        $display("[TB] clear recovery");
        base = strobeCycles.size();
        pulseClear();
        waitCycles(6);
        checkOutput("clearNoStrobe", strobeCycles.size(), base);
        checkOutput("clearIdle", {31'h0, bus.busy}, 32'h0);
        applyStimulus(8'h42);
        t = lastAccept;
        idleInputs();
        waitStrobes(base + 1, "recoverStrobe");
        if (strobeCycles.size() > base)
            checkOutput("recoverLatency", strobeCycles[base] - t, 32'd2);
        waitCycles(3);
        checkOutput("recoverMsgCount", 32'(bus.msg_count), 32'h1);

        // Clear asserted during STROBE
        $display("[TB] clear mid-strobe");
        applyStimulus(8'h44);
        idleInputs();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.enc_inc) break;
        end
        checkOutput("midStrobeSeen", {31'h0, bus.enc_inc}, 32'h1);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midInc", {31'h0, bus.enc_inc}, 32'h0);
        checkOutput("midEncrypt", {31'h0, bus.enc_encrypt}, 32'h0);
        checkOutput("midBusy", {31'h0, bus.busy}, 32'h0);
        checkOutput("midMsgCount", 32'(bus.msg_count), 32'h0);
        @(negedge clk);
        bus.clear = 1'b0;
        sb.delete();
        waitCycles(3);
        checkOutput("midNoHold", {31'h0, bus.busy | bus.enc_encrypt}, 32'h0);

        // Non-printable byte followed by a printable one
        $display("[TB] filter 0x0A, 0x43");
        base = strobeCycles.size();
        applyStimulus(8'h0A);
        d0 = lastDrop;
        applyStimulus(8'h43);
        d1 = lastDrop;
        idleInputs();
`ifdef FEEDER_ASCII_FILTER_EN
        expStrobes = 1;
        checkOutput("dropPulse", {31'h0, d0}, 32'h1);
`else
        expStrobes = 2;
        checkOutput("dropPulse", {31'h0, d0}, 32'h0);
`endif
        checkOutput("dropOneCycle", {31'h0, d1}, 32'h0);
        waitStrobes(base + expStrobes, "filterStrobes");
        waitCycles(8);
        checkOutput("filterNoExtra", strobeCycles.size(), base + expStrobes);
        checkOutput("filterMsgCount", 32'(bus.msg_count), expStrobes);

        // Asynchronous reset in the middle of a strobe
        $display("[TB] reset mid-strobe");
        applyStimulus(8'h45);
        idleInputs();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.enc_inc) break;
        end
        checkOutput("rstStrobeSeen", {31'h0, bus.enc_inc}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arstEncData", {24'h0, bus.enc_data}, 32'h0);
        checkOutput("arstEncrypt", {31'h0, bus.enc_encrypt}, 32'h0);
        checkOutput("arstInc", {31'h0, bus.enc_inc}, 32'h0);
        checkOutput("arstBusy", {31'h0, bus.busy}, 32'h0);
        checkOutput("arstMsgCount", 32'(bus.msg_count), 32'h0);
        checkOutput("arstMsgFull", {31'h0, bus.msg_full}, 32'h0);
        checkOutput("arstDrop", {31'h0, bus.drop_err}, 32'h0);
        checkOutput("arstReady", {31'h0, bus.in_ready}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        #1;
        checkOutput("arstRelReady", {31'h0, bus.in_ready}, 32'h1);
        checkOutput("arstRelBusy", {31'h0, bus.busy}, 32'h0);
        base = strobeCycles.size();
        waitCycles(5);
        checkOutput("arstNoStrobe", strobeCycles.size(), base);
        checkOutput("sbDrained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
